// File: rtl/mips_pipelined.sv
// Five-stage MIPS subset pipeline (IF/ID/EX/MEM/WB) with byte-wide little-endian memories,
// a write-through register file, and branch/jump resolution in EX with a two-slot flush.

module mips_bytemem #(
  parameter  int unsigned BYTES = 256,
  localparam int unsigned WAW   = $clog2(BYTES) - 2
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [WAW-1:0] waddr_i,
  input  logic [31:0]    wdata_i,
  output logic [31:0]    rdata_c_o
);
  logic [7:0] mem_array [BYTES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) mem_array[{waddr_i, 2'(b)}] <= wdata_i[8*b +: 8];
    end
  end

  always_comb begin
    rdata_c_o = '0;
    for (int b = 0; b < 4; b++) rdata_c_o[8*b +: 8] = mem_array[{waddr_i, 2'(b)}];
  end
endmodule

module mips_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_c_o,
  output logic [31:0] rdata_b_c_o
);
  logic [31:0] file_array [32];

  always_ff @(posedge clk_i) begin
    if (we_i && waddr_i != 5'd0) file_array[waddr_i] <= wdata_i;
  end

  // WB write bypasses to the ID read in the same cycle
  always_comb begin
    rdata_a_c_o = file_array[raddr_a_i];
    rdata_b_c_o = file_array[raddr_b_i];
    if (we_i && waddr_i == raddr_a_i) rdata_a_c_o = wdata_i;
    if (we_i && waddr_i == raddr_b_i) rdata_b_c_o = wdata_i;
    if (raddr_a_i == 5'd0) rdata_a_c_o = '0;
    if (raddr_b_i == 5'd0) rdata_b_c_o = '0;
  end
endmodule

module mips_pipelined #(
  parameter int unsigned IMEM_BYTES = 256,
  parameter int unsigned DMEM_BYTES = 256
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned IAW = $clog2(IMEM_BYTES);
  localparam int unsigned DAW = $clog2(DMEM_BYTES);
  localparam logic [5:0] OP_RTYPE = 6'd0,  OP_J  = 6'd2,  OP_BEQ = 6'd4, OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SPEC2 = 6'd28, OP_LW = 6'd35, OP_SW  = 6'd43;
  localparam logic [5:0] FN_SLL  = 6'd0,  FN_MADDU = 6'd1,  FN_SRL = 6'd2,  FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18, FN_MULTU = 6'd25, FN_ADD = 6'd32, FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36, FN_OR    = 6'd37, FN_SLT = 6'd42;

  logic [31:0] pc, pc_q, pc_d, pc_plus4, instr_if;
  logic [31:0] ifid_instr_q, ifid_pc4_q;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val;
  logic [31:0] idex_pc4_q, idex_a_q, idex_b_q, sext;
  logic [5:0]  idex_op_q, idex_fn_q;
  logic [4:0]  idex_rs_q, idex_rt_q, idex_rd_q, idex_sh_q;
  logic [15:0] idex_imm_q;
  logic [63:0] hilo_q, hilo_d;
  logic        redirect;
  logic [31:0] exmem_res_q, exmem_res_d, exmem_b_q;
  logic [4:0]  exmem_dest_q, exmem_dest_d;
  logic        exmem_we_q, exmem_we_d, exmem_rd_q, exmem_rd_d, exmem_wr_q, exmem_wr_d;
  logic [31:0] dmem_rdata, memwb_wd_q, rfile_wd;
  logic [4:0]  memwb_dest_q;
  logic        memwb_we_q;

  assign pc       = pc_q;
  assign pc_plus4 = pc + 32'd4;
  assign opcode   = ifid_instr_q[31:26];
  assign rs       = ifid_instr_q[25:21];
  assign rt       = ifid_instr_q[20:16];
  assign rd       = ifid_instr_q[15:11];
  assign shamt    = ifid_instr_q[10:6];
  assign funct    = ifid_instr_q[5:0];
  assign rfile_wd = memwb_wd_q;
  assign sext     = {{16{idex_imm_q[15]}}, idex_imm_q};

  mips_bytemem #(.BYTES(IMEM_BYTES)) InstrMem (
    .clk_i(clk), .we_i(1'b0), .waddr_i(pc[IAW-1:2]), .wdata_i(32'd0), .rdata_c_o(instr_if)
  );

  mips_regfile RegFile (
    .clk_i(clk), .we_i(memwb_we_q && !rst), .waddr_i(memwb_dest_q), .wdata_i(rfile_wd),
    .raddr_a_i(rs), .raddr_b_i(rt), .rdata_a_c_o(rs_val), .rdata_b_c_o(rt_val)
  );

  mips_bytemem #(.BYTES(DMEM_BYTES)) DatMem (
    .clk_i(clk), .we_i(exmem_wr_q && !rst), .waddr_i(exmem_res_q[DAW-1:2]),
    .wdata_i(exmem_b_q), .rdata_c_o(dmem_rdata)
  );

  // EX: ALU, HI/LO update, branch/jump resolution
  always_comb begin
    exmem_res_d  = '0;
    exmem_dest_d = idex_rd_q;
    exmem_we_d   = 1'b0;
    exmem_rd_d   = 1'b0;
    exmem_wr_d   = 1'b0;
    hilo_d       = hilo_q;
    redirect     = 1'b0;
    pc_d         = pc_plus4;
    unique case (idex_op_q)
      OP_RTYPE: begin
        exmem_we_d = 1'b1;
        unique case (idex_fn_q)
          FN_ADD:   exmem_res_d = idex_a_q + idex_b_q;
          FN_SUB:   exmem_res_d = idex_a_q - idex_b_q;
          FN_AND:   exmem_res_d = idex_a_q & idex_b_q;
          FN_OR:    exmem_res_d = idex_a_q | idex_b_q;
          FN_SLT:   exmem_res_d = {31'd0, $signed(idex_a_q) < $signed(idex_b_q)};
          FN_SRL:   exmem_res_d = idex_b_q >> idex_sh_q;
          FN_SLL:   exmem_res_d = idex_b_q << idex_sh_q;
          FN_MFHI:  exmem_res_d = hilo_q[63:32];
          FN_MFLO:  exmem_res_d = hilo_q[31:0];
          FN_MULTU: begin
            exmem_we_d = 1'b0;
            hilo_d     = {32'd0, idex_a_q} * {32'd0, idex_b_q};
          end
          default:  exmem_we_d = 1'b0;
        endcase
      end
      OP_SPEC2: if (idex_fn_q == FN_MADDU) hilo_d = hilo_q + {32'd0, idex_a_q} * {32'd0, idex_b_q};
      OP_ADDIU, OP_LW: begin
        exmem_res_d  = idex_a_q + sext;
        exmem_dest_d = idex_rt_q;
        exmem_we_d   = 1'b1;
        exmem_rd_d   = (idex_op_q == OP_LW);
      end
      OP_SW: begin
        exmem_res_d = idex_a_q + sext;
        exmem_wr_d  = 1'b1;
      end
      OP_BEQ: if (idex_a_q == idex_b_q) begin
        redirect = 1'b1;
        pc_d     = idex_pc4_q + {sext[29:0], 2'b00};
      end
      OP_J: begin
        redirect = 1'b1;
        pc_d     = {idex_pc4_q[31:28], idex_rs_q, idex_rt_q, idex_imm_q, 2'b00};
      end
      default: ;
    endcase
  end

  // Pipeline registers; a redirect squashes the two younger stages
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      idex_pc4_q   <= '0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      idex_op_q    <= '0;
      idex_fn_q    <= '0;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      idex_sh_q    <= '0;
      idex_imm_q   <= '0;
      hilo_q       <= '0;
      exmem_res_q  <= '0;
      exmem_b_q    <= '0;
      exmem_dest_q <= '0;
      exmem_we_q   <= 1'b0;
      exmem_rd_q   <= 1'b0;
      exmem_wr_q   <= 1'b0;
      memwb_wd_q   <= '0;
      memwb_dest_q <= '0;
      memwb_we_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= redirect ? 32'd0 : instr_if;
      ifid_pc4_q   <= redirect ? 32'd0 : pc_plus4;
      idex_pc4_q   <= redirect ? 32'd0 : ifid_pc4_q;
      idex_a_q     <= redirect ? 32'd0 : rs_val;
      idex_b_q     <= redirect ? 32'd0 : rt_val;
      idex_op_q    <= redirect ? 6'd0 : opcode;
      idex_fn_q    <= redirect ? 6'd0 : funct;
      idex_rs_q    <= redirect ? 5'd0 : rs;
      idex_rt_q    <= redirect ? 5'd0 : rt;
      idex_rd_q    <= redirect ? 5'd0 : rd;
      idex_sh_q    <= redirect ? 5'd0 : shamt;
      idex_imm_q   <= redirect ? 16'd0 : ifid_instr_q[15:0];
      hilo_q       <= hilo_d;
      exmem_res_q  <= exmem_res_d;
      exmem_b_q    <= idex_b_q;
      exmem_dest_q <= exmem_dest_d;
      exmem_we_q   <= exmem_we_d;
      exmem_rd_q   <= exmem_rd_d;
      exmem_wr_q   <= exmem_wr_d;
      memwb_wd_q   <= exmem_rd_q ? dmem_rdata : exmem_res_q;
      memwb_dest_q <= exmem_dest_q;
      memwb_we_q   <= exmem_we_q;
    end
  end
endmodule

// File: tb/tb_mips_pipelined.sv
// Directed program checks plus random NOP-spaced programs compared against an
// instruction-level interpreter of the same program.

module tb_mips_pipelined;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] prog    [64];
  logic [31:0] rf_init [32];
  logic [7:0]  dm_init [256];
  logic [31:0] m_reg   [32];
  logic [7:0]  m_mem   [256];
  logic [31:0] alu_exp [6];
  logic [7:0]  sw_exp  [4];

  mips_pipelined dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd, input int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int idx);
    return {6'd2, 26'(idx)};
  endfunction

  function automatic logic [31:0] enc_maddu(input int rs, input int rt);
    return {6'd28, 5'(rs), 5'(rt), 10'd0, 6'd1};
  endfunction

  function automatic logic [31:0] dm_word(input int a);
    return {dut.DatMem.mem_array[8'(a + 3)], dut.DatMem.mem_array[8'(a + 2)],
            dut.DatMem.mem_array[8'(a + 1)], dut.DatMem.mem_array[8'(a)]};
  endfunction

  function automatic logic [31:0] m_word(input int a);
    return {m_mem[8'(a + 3)], m_mem[8'(a + 2)], m_mem[8'(a + 1)], m_mem[8'(a)]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    for (int i = 0; i < 64; i++) prog[i] = '0;
    for (int i = 0; i < 32; i++) rf_init[i] = '0;
    for (int i = 0; i < 256; i++) dm_init[i] = '0;
  endtask

  // Hold reset while state is preloaded, then release with pc=0 in IF
  task automatic boot();
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 64; i++)
      for (int b = 0; b < 4; b++) dut.InstrMem.mem_array[8'(4*i + b)] = prog[i][8*b +: 8];
    for (int i = 0; i < 32; i++) dut.RegFile.file_array[i] = rf_init[i];
    for (int i = 0; i < 256; i++) dut.DatMem.mem_array[i] = dm_init[i];
    tick(1);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Random instruction for slot k (word 3k); control flow only moves forward
  function automatic logic [31:0] rand_instr(input int k);
    int rs  = $urandom_range(0, 7);
    int rt  = $urandom_range(0, 7);
    int rd  = $urandom_range(0, 7);
    int tgt = $urandom_range(k + 1, 20);
    case ($urandom_range(0, 14))
      0:  return enc_r(32, rs, rt, rd, 0);
      1:  return enc_r(34, rs, rt, rd, 0);
      2:  return enc_r(36, rs, rt, rd, 0);
      3:  return enc_r(37, rs, rt, rd, 0);
      4:  return enc_r(42, rs, rt, rd, 0);
      5:  return enc_r(2, 0, rt, rd, $urandom_range(0, 31));
      6:  return enc_i(9, rs, rt, int'($urandom));
      7:  return enc_i(35, rs, rt, int'($urandom));
      8:  return enc_i(43, rs, rt, int'($urandom));
      9:  return enc_r(25, rs, rt, 0, 0);
      10: return enc_maddu(rs, rt);
      11: return enc_r(16, 0, 0, rd, 0);
      12: return enc_r(18, 0, 0, rd, 0);
      13: return enc_i(4, rs, ($urandom_range(0, 1) != 0) ? rs : rt, 3*tgt - 3*k - 1);
      default: return enc_j(3*tgt);
    endcase
  endfunction

  // Sequential ISA interpreter: one instruction at a time, no pipeline
  task automatic model_run();
    logic [31:0] mpc, w, a, b, se, ea, ld;
    logic [63:0] hl;
    int steps;
    mpc = 0; hl = 0; steps = 0;
    m_reg = rf_init;
    m_reg[0] = 0;
    m_mem = dm_init;
    while (mpc != 32'd240 && steps < 100) begin
      w  = prog[mpc[7:2]];
      a  = m_reg[w[25:21]];
      b  = m_reg[w[20:16]];
      se = {{16{w[15]}}, w[15:0]};
      ea = (a + se) & 32'h0000_00FC;
      mpc = mpc + 4;
      case (w[31:26])
        6'd0: case (w[5:0])
          6'd32: m_reg[w[15:11]] = a + b;
          6'd34: m_reg[w[15:11]] = a - b;
          6'd36: m_reg[w[15:11]] = a & b;
          6'd37: m_reg[w[15:11]] = a | b;
          6'd42: m_reg[w[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'd2:  m_reg[w[15:11]] = b >> w[10:6];
          6'd25: hl = 64'(a) * 64'(b);
          6'd16: m_reg[w[15:11]] = hl[63:32];
          6'd18: m_reg[w[15:11]] = hl[31:0];
          default: ;
        endcase
        6'd28: if (w[5:0] == 6'd1) hl = hl + 64'(a) * 64'(b);
        6'd9:  m_reg[w[20:16]] = a + se;
        6'd35: begin
          for (int i = 0; i < 4; i++) ld[8*i +: 8] = m_mem[8'(ea + 32'(i))];
          m_reg[w[20:16]] = ld;
        end
        6'd43: for (int i = 0; i < 4; i++) m_mem[8'(ea + 32'(i))] = b[8*i +: 8];
        6'd4:  if (a == b) mpc = mpc + (se << 2);
        6'd2:  mpc = {mpc[31:28], w[25:0], 2'b00};
        default: ;
      endcase
      m_reg[0] = 0;
      steps++;
    end
  endtask

  initial begin
    alu_exp = '{32'd8, 32'd2, 32'd1, 32'd7, 32'd1, 32'd2};
    sw_exp  = '{8'h08, 8'h00, 8'h00, 8'h00};

    // Reset and sequential fetch over NOPs
    clear();
    for (int i = 1; i < 32; i++) rf_init[i] = 32'(i) * 32'h0101_0101;
    boot();
    chk("reset_pc", dut.pc, 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick(1);
      chk("fetch_pc", dut.pc, 32'(4*k));
    end
    tick(6);
    for (int i = 1; i < 32; i++) chk("nop_reg", dut.RegFile.file_array[i], 32'(i) * 32'h0101_0101);

    // ALU ops, WB data observed cycle by cycle
    clear();
    rf_init[1] = 32'd5;
    rf_init[2] = 32'd3;
    prog[0] = enc_r(32, 1, 2, 3, 0);
    prog[1] = enc_r(34, 1, 2, 4, 0);
    prog[2] = enc_r(36, 1, 2, 5, 0);
    prog[3] = enc_r(37, 1, 2, 6, 0);
    prog[4] = enc_r(42, 2, 1, 7, 0);
    prog[5] = enc_r(2, 0, 1, 8, 1);
    boot();
    tick(4);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("alu_wd%0d", k), dut.rfile_wd, alu_exp[k]);
      tick(1);
    end
    tick(2);
    for (int k = 0; k < 6; k++) chk($sformatf("alu_r%0d", k + 3), dut.RegFile.file_array[k + 3], alu_exp[k]);

    // Store then load
    clear();
    prog[0] = enc_i(9, 0, 1, 8);
    prog[3] = enc_i(43, 0, 1, 4);
    prog[4] = enc_i(35, 0, 2, 4);
    boot();
    tick(12);
    for (int i = 0; i < 4; i++) chk($sformatf("sw_byte%0d", i + 4), 32'(dut.DatMem.mem_array[4 + i]), 32'(sw_exp[i]));
    chk("lw_r2", dut.RegFile.file_array[2], 32'd8);

    // MULTU / MADDU with back-to-back HI/LO reads
    clear();
    rf_init[1] = 32'hFFFF_FFFF;
    rf_init[2] = 32'd2;
    prog[0] = enc_r(25, 1, 2, 0, 0);
    prog[1] = enc_r(16, 0, 0, 3, 0);
    prog[2] = enc_r(18, 0, 0, 4, 0);
    prog[3] = enc_maddu(1, 2);
    prog[4] = enc_r(18, 0, 0, 5, 0);
    prog[5] = enc_r(16, 0, 0, 6, 0);
    boot();
    tick(12);
    chk("mfhi_r3", dut.RegFile.file_array[3], 32'd1);
    chk("mflo_r4", dut.RegFile.file_array[4], 32'hFFFF_FFFE);
    chk("maddu_r5", dut.RegFile.file_array[5], 32'hFFFF_FFFC);
    chk("maddu_r6", dut.RegFile.file_array[6], 32'd3);

    // Taken BEQ flushes the two following fetches
    clear();
    prog[0] = enc_i(4, 0, 0, 2);
    prog[1] = enc_i(9, 0, 9, 1);
    prog[2] = enc_i(9, 0, 10, 1);
    prog[3] = enc_i(9, 0, 11, 7);
    boot();
    tick(1); chk("beq_pc1", dut.pc, 32'd4);
    tick(1); chk("beq_pc2", dut.pc, 32'd8);
    tick(1); chk("beq_tgt", dut.pc, 32'd12);
    tick(8);
    chk("beq_r9", dut.RegFile.file_array[9], 32'd0);
    chk("beq_r10", dut.RegFile.file_array[10], 32'd0);
    chk("beq_r11", dut.RegFile.file_array[11], 32'd7);

    // Jump, then reset while a SW sits in MEM
    clear();
    prog[0]  = enc_j(16);
    prog[1]  = enc_i(9, 0, 12, 1);
    prog[16] = enc_i(9, 0, 1, 32'h55);
    prog[19] = enc_i(43, 0, 1, 32'h20);
    boot();
    tick(3); chk("j_pc", dut.pc, 32'h40);
    tick(3); chk("sw_fetch_pc", dut.pc, 32'h4C);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("rst_pc", dut.pc, 32'd0);
    chk("rst_sw_drop", dm_word(32'h20), 32'd0);
    chk("j_r1", dut.RegFile.file_array[1], 32'h55);
    chk("j_flush_r12", dut.RegFile.file_array[12], 32'd0);
    tick(3);
    chk("rst_hold_pc", dut.pc, 32'd0);
    chk("rst_sw_drop2", dm_word(32'h20), 32'd0);

    // Random NOP-spaced programs against the interpreter
    for (int p = 0; p < 16; p++) begin
      clear();
      for (int i = 1; i < 32; i++) rf_init[i] = pick_val();
      for (int i = 0; i < 256; i++) dm_init[i] = 8'($urandom);
      for (int k = 0; k < 18; k++) prog[3*k] = rand_instr(k);
      prog[54] = enc_r(16, 0, 0, 30, 0);
      prog[57] = enc_r(18, 0, 0, 31, 0);
      prog[60] = enc_j(60);
      model_run();
      boot();
      tick(120);
      chk($sformatf("rnd%0d_halt_pc", p), {dut.pc[31:4], 4'd0}, 32'd240);
      for (int i = 1; i < 32; i++)
        chk($sformatf("rnd%0d_r%0d", p, i), dut.RegFile.file_array[i], m_reg[i]);
      for (int i = 0; i < 64; i++)
        chk($sformatf("rnd%0d_m%0d", p, 4*i), dm_word(4*i), m_word(4*i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
